lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker.sv | 124 ++++++++++++
 tb/tb_lfsr_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the x^8+x^6+x^5+x^4+1 LFSR stream; all outputs registered, 1-cycle latency.
// No backpressure: every valid beat is consumed the cycle it is presented.
module lfsr_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_CNT);
  localparam logic [3:0]       RUN_ONE  = 4'd1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       exp_q, exp_d;
  logic [3:0]       run_q, run_d;     // match run in VERIFY, miss run in LOCKED
  logic             err_q, err_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic [CNT_W-1:0] wordc_q, wordc_d;
  logic             hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q   <= 8'h00;
      run_q   <= 4'd0;
      err_q   <= 1'b0;
      errc_q  <= '0;
      wordc_q <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
      wordc_q <= wordc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    err_d   = 1'b0;
    errc_d  = errc_q;
    wordc_d = wordc_q;
    hit     = (in_data == exp_q);
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_data != 8'h00) begin
            exp_d   = lfsr_next(in_data);
            run_d   = 4'd0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            exp_d = lfsr_next(exp_q);
            run_d = run_q + RUN_ONE;
            if (run_q + RUN_ONE == LOCK_N) begin
              state_d = LOCKED;
              run_d   = 4'd0;
            end
          end else if (in_data != 8'h00) begin
            // Reseed from the offending word so no beat is lost.
            exp_d = lfsr_next(in_data);
            run_d = 4'd0;
          end else begin
            state_d = HUNT;
            run_d   = 4'd0;
          end
        end
        LOCKED: begin
          exp_d = lfsr_next(exp_q);
          if (wordc_q != {CNT_W{1'b1}}) wordc_d = wordc_q + CNT_ONE;
          if (hit) begin
            run_d = 4'd0;
          end else begin
            err_d = 1'b1;
            if (errc_q != {CNT_W{1'b1}}) errc_d = errc_q + CNT_ONE;
            run_d = run_q + RUN_ONE;
            if (run_q + RUN_ONE == UNLOCK_N) begin
              state_d = HUNT;
              run_d   = 4'd0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = 4'd0;
        end
      endcase
    end
    if (clr_cnt) begin
      errc_d  = '0;
      wordc_d = '0;
    end
  end

  always_comb begin
    locked   = (state_q == LOCKED);
    err_flag = err_q;
    err_cnt  = errc_q;
    word_cnt = wordc_q;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised and directed bench for lfsr_checker; two instances (default and CNT_W=4/UNLOCK_CNT=15)
// are compared every cycle against a sequence-table reference model.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clr_cnt = 1'b0;

  logic        m_locked, m_err_flag;
  logic [15:0] m_err_cnt, m_word_cnt;
  logic        s_locked, s_err_flag;
  logic [3:0]  s_err_cnt, s_word_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(m_locked), .err_flag(m_err_flag), .err_cnt(m_err_cnt), .word_cnt(m_word_cnt)
  );

  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(s_locked), .err_flag(s_err_flag), .err_cnt(s_err_cnt), .word_cnt(s_word_cnt)
  );

  // The 255-long sequence starting at 0x01 and the position of each value in it.
  logic [7:0] seq [255];
  int         pos [256];
  int         gen_idx = 0;

  // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked.
  int         mode [2];
  int         run  [2];
  int         errc [2];
  int         wordc[2];
  int         ef   [2];
  logic [7:0] ex   [2];
  int         lk_p [2] = '{4, 4};
  int         ul_p [2] = '{3, 15};
  int         mx_p [2] = '{65535, 15};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [7:0] succ(input logic [7:0] v);
    return seq[(pos[v] + 1) % 255];
  endfunction

  task automatic model_step(input int k);
    int ef_n;
    if (rst) begin
      mode[k] = 0; run[k] = 0; errc[k] = 0; wordc[k] = 0; ef[k] = 0; ex[k] = 8'h00;
    end else begin
      ef_n = 0;
      if (in_valid) begin
        if (mode[k] == 0) begin
          if (in_data != 8'h00) begin
            ex[k] = succ(in_data); run[k] = 0; mode[k] = 1;
          end
        end else if (mode[k] == 1) begin
          if (in_data == ex[k]) begin
            ex[k] = succ(ex[k]); run[k]++;
            if (run[k] == lk_p[k]) begin mode[k] = 2; run[k] = 0; end
          end else if (in_data != 8'h00) begin
            ex[k] = succ(in_data); run[k] = 0;
          end else begin
            mode[k] = 0; run[k] = 0;
          end
        end else begin
          if (wordc[k] < mx_p[k]) wordc[k]++;
          if (in_data == ex[k]) begin
            run[k] = 0;
          end else begin
            ef_n = 1;
            if (errc[k] < mx_p[k]) errc[k]++;
            run[k]++;
            if (run[k] == ul_p[k]) begin mode[k] = 0; run[k] = 0; end
          end
          ex[k] = succ(ex[k]);
        end
      end
      if (clr_cnt) begin errc[k] = 0; wordc[k] = 0; end
      ef[k] = ef_n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("m.locked",   32'(m_locked),   32'(mode[0] == 2));
    check("m.err_flag", 32'(m_err_flag), 32'(ef[0]));
    check("m.err_cnt",  32'(m_err_cnt),  32'(errc[0]));
    check("m.word_cnt", 32'(m_word_cnt), 32'(wordc[0]));
    check("s.locked",   32'(s_locked),   32'(mode[1] == 2));
    check("s.err_flag", 32'(s_err_flag), 32'(ef[1]));
    check("s.err_cnt",  32'(s_err_cnt),  32'(errc[1]));
    check("s.word_cnt", 32'(s_word_cnt), 32'(wordc[1]));
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    in_valid = v; in_data = d; clr_cnt = c;
    tick();
  endtask

  task automatic good();
    drive(1'b1, seq[gen_idx], 1'b0);
    gen_idx = (gen_idx + 1) % 255;
  endtask

  task automatic bad(input logic c);
    drive(1'b1, seq[gen_idx] ^ 8'h01, c);
    gen_idx = (gen_idx + 1) % 255;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 5; i++) good();
  endtask

  initial begin
    logic [7:0] s;
    int r;
    s = 8'h01;
    for (int i = 0; i < 255; i++) begin
      seq[i] = s;
      pos[s] = i;
      s = ((s << 1) & 8'hFE) | 8'(s[7] ^ s[5] ^ s[4] ^ s[3]);
    end
    pos[0] = 0;

    // Reset and first lock-up from 0x01.
    do_reset(2);
    check("rst.locked", 32'(m_locked), 0);
    check("rst.err_cnt", 32'(m_err_cnt), 0);
    gen_idx = 0;
    for (int i = 0; i < 4; i++) good();
    check("lock.before5", 32'(m_locked), 0);
    good();
    check("lock.after5", 32'(m_locked), 1);
    check("lock.err0", 32'(m_err_cnt), 0);
    for (int i = 0; i < 300; i++) good();
    check("run300.err", 32'(m_err_cnt), 0);
    check("run300.words", 32'(m_word_cnt), 300);
    check("sat.words", 32'(s_word_cnt), 15);

    // Single corruption while locked.
    bad(1'b0);
    check("corrupt.flag", 32'(m_err_flag), 1);
    check("corrupt.err", 32'(m_err_cnt), 1);
    good();
    check("corrupt.flag_off", 32'(m_err_flag), 0);
    check("corrupt.locked", 32'(m_locked), 1);

    // Loss of sync with three zero words, then relock.
    drive(1'b1, 8'h00, 1'b0); gen_idx++;
    drive(1'b1, 8'h00, 1'b0); gen_idx++;
    check("zero2.locked", 32'(m_locked), 1);
    drive(1'b1, 8'h00, 1'b0); gen_idx++;
    check("zero3.locked", 32'(m_locked), 0);
    check("zero3.err", 32'(m_err_cnt), 4);
    for (int i = 0; i < 4; i++) good();
    check("relock.before", 32'(m_locked), 0);
    good();
    check("relock.after", 32'(m_locked), 1);

    // Gapped stream.
    do_reset(2);
    gen_idx = 37;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("gap.before", 32'(m_locked), 0);
      good();
      drive(1'b0, 8'hA5, 1'b0);
    end
    check("gap.locked", 32'(m_locked), 1);
    for (int i = 0; i < 3; i++) begin
      good();
      drive(1'b0, 8'h5A, 1'b0);
    end
    check("gap.words", 32'(m_word_cnt), 3);

    // All-zero input never leaves HUNT.
    do_reset(2);
    for (int i = 0; i < 40; i++) drive(1'b1, 8'h00, 1'b0);
    check("zero_hunt.locked", 32'(m_locked), 0);

    // Clear coinciding with a corrupted beat.
    gen_idx = 100;
    lock_up();
    for (int i = 0; i < 5; i++) good();
    bad(1'b1);
    check("clr.err", 32'(m_err_cnt), 0);
    check("clr.words", 32'(m_word_cnt), 0);
    check("clr.flag", 32'(m_err_flag), 1);
    check("clr.locked", 32'(m_locked), 1);

    // Saturation of err_cnt on the narrow instance.
    do_reset(1);
    lock_up();
    for (int i = 0; i < 20; i++) begin bad(1'b0); good(); end
    check("sat.alt_err", 32'(s_err_cnt), 15);
    check("sat.alt_main", 32'(m_err_cnt), 20);
    do_reset(1);
    lock_up();
    for (int i = 0; i < 20; i++) bad(1'b0);
    check("sat.run_err", 32'(s_err_cnt), 15);
    check("sat.run_locked", 32'(s_locked), 0);

    // Reset while locked with two errors recorded.
    do_reset(1);
    lock_up();
    bad(1'b0); good(); bad(1'b0); good();
    check("midrst.pre_err", 32'(m_err_cnt), 2);
    rst = 1'b1;
    drive(1'b1, seq[gen_idx], 1'b0);
    rst = 1'b0;
    check("midrst.locked", 32'(m_locked), 0);
    check("midrst.err", 32'(m_err_cnt), 0);
    check("midrst.words", 32'(m_word_cnt), 0);
    check("midrst.flag", 32'(m_err_flag), 0);

    // Randomised mix, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      rst = ($urandom_range(0, 199) == 0);
      clr_cnt = 1'b0;
      if (r < 60) begin
        drive(1'b1, seq[gen_idx], ($urandom_range(0, 32) == 0));
        gen_idx = (gen_idx + 1) % 255;
      end else if (r < 70) begin
        drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      end else if (r < 78) begin
        drive(1'b1, seq[gen_idx] ^ 8'($urandom_range(1, 255)), 1'b0);
        gen_idx = (gen_idx + 1) % 255;
      end else if (r < 82) begin
        drive(1'b1, 8'h00, 1'b0);
      end else if (r < 85) begin
        drive(1'b1, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      end else begin
        gen_idx = $urandom_range(0, 254);
        drive(1'b1, seq[gen_idx], 1'b0);
        gen_idx = (gen_idx + 1) % 255;
      end
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
